// File: rtl/hazard5_frontend_pkg.sv
// Shared types and helpers for the Hazard5 instruction fetch frontend.
package hazard5_frontend_pkg;

    localparam int W_CIR_CNT = 2;
    localparam int W_HW      = 16;
    localparam int CIR_HW    = 3;

    typedef logic [W_HW-1:0] halfword_t;

    // Decode only ever sees two halfwords even when the third slot is full.
    function automatic logic [W_CIR_CNT-1:0] cir_visible(input logic [W_CIR_CNT-1:0] level);
        return (level == 2'd3) ? 2'd2 : level;
    endfunction

endpackage

// File: rtl/hazard5_prefetch_fifo.sv
// Small synchronous word FIFO with flush and occupancy output.
module hazard5_prefetch_fifo #(
    parameter int W_DATA = 32,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [W_DATA-1:0]           wdata,
    input  logic                        pop,
    input  logic                        flush,
    output logic [W_DATA-1:0]           rdata,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        empty
);

    localparam int W_PTR = $clog2(DEPTH);
    localparam int W_LVL = W_PTR + 1;

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [W_PTR-1:0]  wptr_q;
    logic [W_PTR-1:0]  rptr_q;
    logic [W_LVL-1:0]  level_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + W_PTR'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + W_PTR'(1);
            end
            level_q <= level_q + W_LVL'(push) - W_LVL'(pop);
        end
    end

    assign rdata = mem_q[rptr_q];
    assign level = level_q;
    assign empty = (level_q == '0);

endmodule

// File: rtl/hazard5_frontend.sv
// Hazard5 fetch stage: throttled word fetch, prefetch FIFO and a
// halfword-granular current instruction register feeding decode.
module hazard5_frontend
    import hazard5_frontend_pkg::*;
#(
    parameter int                W_ADDR       = 32,
    parameter int                W_DATA       = 32,
    parameter int                FIFO_DEPTH   = 2,
    parameter logic [W_ADDR-1:0] RESET_VECTOR = '0,
    parameter bit                EXTENSION_C  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [W_ADDR-1:0]    mem_addr,
    output logic                 mem_addr_vld,
    input  logic                 mem_addr_rdy,
    input  logic [W_DATA-1:0]    mem_data,
    input  logic                 mem_data_vld,
    output logic [31:0]          fd_cir,
    output logic [W_CIR_CNT-1:0] fd_cir_vld,
    input  logic [W_CIR_CNT-1:0] df_cir_use,
    input  logic                 df_cir_lock,
    input  logic                 d_jump_req,
    input  logic [W_ADDR-1:0]    d_jump_target,
    input  logic                 x_jump_req,
    input  logic [W_ADDR-1:0]    x_jump_target,
    output logic                 f_jump_rdy,
    output logic                 f_jump_now,
    output logic [W_ADDR-1:0]    f_jump_target
);

    localparam int W_LVL = $clog2(FIFO_DEPTH) + 1;

    logic [W_ADDR-1:0]               fetch_addr_q, fetch_addr_d;
    logic [2:0]                      pending_q, pending_d;
    logic [2:0]                      discard_q, discard_d;
    logic [CIR_HW-1:0][W_HW-1:0]     cir_q, cir_d;
    logic [W_CIR_CNT-1:0]            level_q, level_d;
    logic                            jumped_locked_q, jumped_locked_d;
    logic                            skip_half_q, skip_half_d;

    logic                            jump_now;
    logic [W_ADDR-1:0]               jump_target;
    logic                            issue_room;
    logic                            addr_accept;
    logic                            data_in_vld;

    logic [W_DATA-1:0]               fifo_rdata;
    logic [W_LVL-1:0]                fifo_level;
    logic                            fifo_empty;
    logic                            fifo_push;
    logic                            fifo_pop;

    logic [W_CIR_CNT-1:0]            level_shift;
    logic [CIR_HW-1:0][W_HW-1:0]     cir_shift;
    logic [W_CIR_CNT:0]              src;
    logic                            do_fill;
    logic [W_DATA-1:0]               fill_word;

    // Jumps ride on the address phase: no accept, no redirect.
    assign jump_target   = x_jump_req ? x_jump_target : d_jump_target;
    assign jump_now      = rst_n & mem_addr_rdy & (x_jump_req | d_jump_req);
    assign f_jump_now    = jump_now;
    assign f_jump_rdy    = mem_addr_rdy & ~x_jump_req;
    assign f_jump_target = jump_target;

    assign issue_room   = (32'(fifo_level) + 32'(pending_q)) < 32'(FIFO_DEPTH);
    assign mem_addr_vld = rst_n & (jump_now | issue_room);
    assign mem_addr     = jump_now ? {jump_target[W_ADDR-1:2], 2'b00} : fetch_addr_q;
    assign addr_accept  = mem_addr_vld & mem_addr_rdy;

    // A word returning in the jump cycle still belongs to the old stream.
    assign data_in_vld = mem_data_vld & ~jump_now & (discard_q == 3'd0);

    always_comb begin
        fetch_addr_d = addr_accept ? mem_addr + W_ADDR'(4) : fetch_addr_q;
        pending_d    = pending_q + {2'b00, addr_accept} - {2'b00, mem_data_vld};
        discard_d    = discard_q;
        if (jump_now) begin
            discard_d = pending_q - {2'b00, mem_data_vld};
        end else if (mem_data_vld && discard_q != 3'd0) begin
            discard_d = discard_q - 3'd1;
        end
    end

    always_comb begin
        level_shift     = (jumped_locked_q && !df_cir_lock) ? '0 : level_q - df_cir_use;
        src             = '0;
        cir_shift       = '0;
        for (int i = 0; i < CIR_HW; i++) begin
            src = 3'(i) + {1'b0, df_cir_use};
            if (2'(i) < level_shift && src < 3'(CIR_HW)) begin
                cir_shift[i] = cir_q[src[1:0]];
            end
        end

        do_fill         = ~jump_now & ~df_cir_lock & (level_shift <= 2'd1)
                          & (~fifo_empty | data_in_vld);
        fill_word       = fifo_empty ? mem_data : fifo_rdata;
        cir_d           = cir_shift;
        level_d         = level_shift;
        skip_half_d     = skip_half_q;
        jumped_locked_d = jumped_locked_q & df_cir_lock;

        if (do_fill) begin
            if (skip_half_q) begin
                cir_d[level_shift] = fill_word[31:16];
                level_d            = level_shift + 2'd1;
                skip_half_d        = 1'b0;
            end else begin
                cir_d[level_shift]        = fill_word[15:0];
                cir_d[level_shift + 2'd1] = fill_word[31:16];
                level_d                   = level_shift + 2'd2;
            end
        end

        // A locked CIR keeps its contents; the flush is deferred to unlock.
        if (jump_now) begin
            skip_half_d = EXTENSION_C & jump_target[1];
            if (df_cir_lock) begin
                jumped_locked_d = 1'b1;
            end else begin
                cir_d   = '0;
                level_d = '0;
            end
        end
    end

    assign fifo_pop  = do_fill & ~fifo_empty;
    assign fifo_push = data_in_vld & ~(do_fill & fifo_empty);

    hazard5_prefetch_fifo #(
        .W_DATA (W_DATA),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (mem_data),
        .pop   (fifo_pop),
        .flush (jump_now),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q    <= RESET_VECTOR;
            pending_q       <= '0;
            discard_q       <= '0;
            cir_q           <= '0;
            level_q         <= '0;
            jumped_locked_q <= 1'b0;
            skip_half_q     <= 1'b0;
        end else begin
            fetch_addr_q    <= fetch_addr_d;
            pending_q       <= pending_d;
            discard_q       <= discard_d;
            cir_q           <= cir_d;
            level_q         <= level_d;
            jumped_locked_q <= jumped_locked_d;
            skip_half_q     <= skip_half_d;
        end
    end

    assign fd_cir     = {cir_q[1], cir_q[0]};
    assign fd_cir_vld = cir_visible(level_q);

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst_n) df_cir_use <= fd_cir_vld);
`endif

endmodule
